// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if: instruction-memory read bus (req/ack handshake)
interface if_fetch_stage_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, addr, input ack, rdata);
    modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction fetch with req/ack memory, one-entry skid buffer and IF/ID register
// Optional performance counters are built when FETCH_PERF_EN is defined.
module if_fetch_stage #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [ADDR_W-1:0] next_pc_i,
    input  logic              hazard_i,
    input  logic              flush_i,
    if_fetch_stage_if.master  imem,
    output logic              pc_en_o,
    output logic              ifid_valid_o,
    output logic [ADDR_W-1:0] ifid_pc_o,
    output logic [ADDR_W-1:0] ifid_pc4_o,
    output logic [DATA_W-1:0] ifid_instr_o,
    output logic [31:0]       perf_fetch_o,
    output logic [31:0]       perf_stall_o
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_BUF, S_DRAIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, target_q;
    logic [DATA_W-1:0] buf_q;
    logic              pc_en, ld_mem, ld_buf, bubble, buf_ld, tgt_ld;
    logic              addr_pc, addr_next, addr_tgt;

    assign imem.req  = (state_q == S_REQ) || (state_q == S_DRAIN);
    assign imem.addr = addr_q;
    assign pc_en_o   = pc_en;

    // State register; reset abandons any outstanding request
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: flush outranks hazard; a flush without ack must wait out the pending read
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = start_i ? S_REQ : S_IDLE;
            S_REQ:   state_d = flush_i ? (imem.ack ? S_REQ : S_DRAIN)
                                       : ((imem.ack && hazard_i) ? S_BUF : S_REQ);
            S_BUF:   state_d = (flush_i || !hazard_i) ? S_REQ : S_BUF;
            S_DRAIN: state_d = imem.ack ? S_REQ : S_DRAIN;
            default: state_d = S_IDLE;
        endcase
    end

    // Per-state control strobes for PC enable, address, skid buffer and IF/ID slot
    always_comb begin
        pc_en     = 1'b0;
        ld_mem    = 1'b0;
        ld_buf    = 1'b0;
        bubble    = 1'b0;
        buf_ld    = 1'b0;
        tgt_ld    = 1'b0;
        addr_pc   = 1'b0;
        addr_next = 1'b0;
        addr_tgt  = 1'b0;
        case (state_q)
            S_IDLE: addr_pc = start_i;
            S_REQ: begin
                if (flush_i) begin
                    bubble    = 1'b1;
                    pc_en     = 1'b1;
                    addr_next = imem.ack;
                    tgt_ld    = !imem.ack;
                end else if (imem.ack) begin
                    ld_mem    = !hazard_i;
                    pc_en     = !hazard_i;
                    addr_next = !hazard_i;
                    buf_ld    = hazard_i;
                end else begin
                    bubble    = !hazard_i;
                end
            end
            S_BUF: begin
                bubble    = flush_i;
                ld_buf    = !flush_i && !hazard_i;
                pc_en     = flush_i || !hazard_i;
                addr_next = flush_i || !hazard_i;
            end
            S_DRAIN: begin
                bubble    = 1'b1;
                pc_en     = flush_i;
                addr_next = flush_i && imem.ack;
                tgt_ld    = flush_i && !imem.ack;
                addr_tgt  = !flush_i && imem.ack;
            end
            default: ;
        endcase
    end

    // Fetch address, skid buffer and drain target registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            addr_q   <= '0;
            target_q <= '0;
            buf_q    <= '0;
        end else begin
            if (addr_pc)        addr_q <= pc_i;
            else if (addr_next) addr_q <= next_pc_i;
            else if (addr_tgt)  addr_q <= target_q;
            if (tgt_ld) target_q <= next_pc_i;
            if (buf_ld) buf_q <= imem.rdata;
        end
    end

    // IF/ID register: load from memory or skid buffer, bubble, or hold
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ifid_valid_o <= 1'b0;
            ifid_pc_o    <= '0;
            ifid_pc4_o   <= '0;
            ifid_instr_o <= NOP_INSTR;
        end else if (ld_mem || ld_buf) begin
            ifid_valid_o <= 1'b1;
            ifid_pc_o    <= addr_q;
            ifid_pc4_o   <= addr_q + ADDR_W'(4);
            ifid_instr_o <= ld_buf ? buf_q : imem.rdata;
        end else if (bubble) begin
            ifid_valid_o <= 1'b0;
            ifid_instr_o <= NOP_INSTR;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_q, stall_q;

    // Delivered-instruction and ack-wait counters, free-running and wrapping
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_q <= '0;
            stall_q <= '0;
        end else begin
            if (ld_mem || ld_buf)                  fetch_q <= fetch_q + 32'd1;
            if (state_q == S_REQ && !imem.ack)     stall_q <= stall_q + 32'd1;
        end
    end

    assign perf_fetch_o = fetch_q;
    assign perf_stall_o = stall_q;
`else
    assign perf_fetch_o = '0;
    assign perf_stall_o = '0;
`endif
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed-vector bench for if_fetch_stage
module tb_if_fetch_stage;
    localparam logic [31:0] NOP = 32'h0;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [31:0] pc_i, next_pc_i;
    logic        hazard_i, flush_i;
    logic        pc_en_o, ifid_valid_o;
    logic [31:0] ifid_pc_o, ifid_pc4_o, ifid_instr_o, perf_fetch_o, perf_stall_o;
    int          n_cmp = 0;
    int          n_err = 0;

    if_fetch_stage_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    if_fetch_stage #(.ADDR_W(32), .DATA_W(32), .NOP_INSTR(NOP)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .pc_i         (pc_i),
        .next_pc_i    (next_pc_i),
        .hazard_i     (hazard_i),
        .flush_i      (flush_i),
        .imem         (bus.master),
        .pc_en_o      (pc_en_o),
        .ifid_valid_o (ifid_valid_o),
        .ifid_pc_o    (ifid_pc_o),
        .ifid_pc4_o   (ifid_pc4_o),
        .ifid_instr_o (ifid_instr_o),
        .perf_fetch_o (perf_fetch_o),
        .perf_stall_o (perf_stall_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic a, input logic [31:0] d, input logic [31:0] np,
                         input logic hz, input logic fl);
        bus.ack   = a;
        bus.rdata = d;
        next_pc_i = np;
        hazard_i  = hz;
        flush_i   = fl;
        #1;
    endtask

    task automatic slot(input string tag, input logic [31:0] pc, input logic [31:0] instr);
        check({tag, "_valid"}, ifid_valid_o, 1);
        check({tag, "_pc"}, ifid_pc_o, pc);
        check({tag, "_pc4"}, ifid_pc4_o, pc + 32'd4);
        check({tag, "_instr"}, ifid_instr_o, instr);
    endtask

    initial begin
        rst_i = 1'b0; start_i = 1'b0; pc_i = '0; next_pc_i = '0;
        hazard_i = 1'b0; flush_i = 1'b0; bus.ack = 1'b0; bus.rdata = '0;
        #12;
        check("rst_req", bus.req, 0);
        check("rst_addr", bus.addr, 0);
        check("rst_pc_en", pc_en_o, 0);
        check("rst_valid", ifid_valid_o, 0);
        check("rst_instr", ifid_instr_o, NOP);
        rst_i = 1'b1;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("t1_req", bus.req, 1);
        check("t1_addr", bus.addr, 32'h0);
        drive(1, 32'hAAAA_0001, 32'h4, 0, 0);
        check("t1_pc_en_a", pc_en_o, 1);
        tick();
        slot("t1_a", 32'h0, 32'hAAAA_0001);
        drive(1, 32'hBBBB_0002, 32'h8, 0, 0);
        check("t1_pc_en_b", pc_en_o, 1);
        tick();
        slot("t1_b", 32'h4, 32'hBBBB_0002);
        drive(1, 32'hCCCC_0003, 32'h10, 0, 0);
        tick();
        slot("t1_c", 32'h8, 32'hCCCC_0003);
        for (int i = 0; i < 3; i++) begin
            drive(0, 32'hDEAD_BEEF, 32'h14, 0, 0);
            check("t2_addr", bus.addr, 32'h10);
            check("t2_req", bus.req, 1);
            check("t2_pc_en", pc_en_o, 0);
            tick();
            check("t2_valid", ifid_valid_o, 0);
        end
        drive(1, 32'hDDDD_0004, 32'h20, 0, 0);
        check("t2_pc_en", pc_en_o, 1);
        tick();
        slot("t2_d", 32'h10, 32'hDDDD_0004);
        drive(1, 32'hEEEE_0005, 32'h24, 1, 0);
        check("t3_pc_en_ack", pc_en_o, 0);
        tick();
        slot("t3_hold1", 32'h10, 32'hDDDD_0004);
        drive(0, 32'h0, 32'h24, 1, 0);
        check("t3_req", bus.req, 0);
        check("t3_pc_en", pc_en_o, 0);
        tick();
        slot("t3_hold2", 32'h10, 32'hDDDD_0004);
        drive(0, 32'h0, 32'h24, 0, 0);
        check("t3_pc_en_rel", pc_en_o, 1);
        tick();
        slot("t3_e", 32'h20, 32'hEEEE_0005);
        check("t3_addr", bus.addr, 32'h24);
        drive(0, 32'h0, 32'h40, 0, 1);
        check("t4_pc_en", pc_en_o, 1);
        tick();
        check("t4_valid", ifid_valid_o, 0);
        check("t4_addr_held", bus.addr, 32'h24);
        check("t4_req", bus.req, 1);
        drive(0, 32'h0, 32'h28, 0, 0);
        check("t4_pc_en_wait", pc_en_o, 0);
        tick();
        drive(1, 32'hBAD0_0024, 32'h28, 0, 0);
        check("t4_pc_en_ack", pc_en_o, 0);
        tick();
        check("t4_valid_after", ifid_valid_o, 0);
        check("t4_instr_after", ifid_instr_o, NOP);
        check("t4_addr_new", bus.addr, 32'h40);
        check("t4_req_new", bus.req, 1);
        drive(1, 32'hFFFF_0006, 32'h44, 1, 1);
        check("t5_pc_en", pc_en_o, 1);
        tick();
        check("t5_valid", ifid_valid_o, 0);
        check("t5_addr", bus.addr, 32'h44);
        drive(1, 32'h1234_0007, 32'h48, 0, 0);
        tick();
        slot("t5_g", 32'h44, 32'h1234_0007);
`ifdef FETCH_PERF_EN
        check("perf_fetch_pre", perf_fetch_o, 6);
        check("perf_stall_pre", perf_stall_o, 4);
`else
        check("perf_fetch_off", perf_fetch_o, 0);
        check("perf_stall_off", perf_stall_o, 0);
`endif
        drive(0, 32'h0, 32'h4C, 0, 0);
        check("t5_req_pend", bus.req, 1);
        #1;
        rst_i = 1'b0;
        #1;
        check("t5_rst_req", bus.req, 0);
        check("t5_rst_addr", bus.addr, 0);
        check("t5_rst_valid", ifid_valid_o, 0);
        check("t5_rst_pc", ifid_pc_o, 0);
        check("t5_rst_pc4", ifid_pc4_o, 0);
        check("t5_rst_instr", ifid_instr_o, NOP);
        check("t5_rst_pc_en", pc_en_o, 0);
        tick();
        rst_i = 1'b1;
        start_i = 1'b1;
        pc_i = 32'hFFFF_FFFC;
        tick();
        start_i = 1'b0;
        check("t6_addr", bus.addr, 32'hFFFF_FFFC);
        drive(1, 32'h5555_0008, 32'h0, 0, 0);
        tick();
        check("t6_pc", ifid_pc_o, 32'hFFFF_FFFC);
        check("t6_pc4", ifid_pc4_o, 32'h0);
        check("t6_instr", ifid_instr_o, 32'h5555_0008);
`ifdef FETCH_PERF_EN
        check("perf_fetch_post", perf_fetch_o, 1);
        check("perf_stall_post", perf_stall_o, 0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
